// File: rtl/dual_rail_pkg.sv
// Shared dual-rail protocol definitions: symbol codes, channel/direction codes, receiver states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dual_rail_pkg;

  // Receiver control states; WAIT_SPACER holds ack high until the rails return to zero.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_GET_CH      = 3'd1,
    ST_GET_DIR     = 3'd2,
    ST_GET_END     = 3'd3,
    ST_WAIT_SPACER = 3'd4
  } rx_state_e;

  // Symbol encoding on {bit1, bit0}.
  localparam logic [1:0] SYM_SPACER = 2'b00;
  localparam logic [1:0] SYM_ZERO   = 2'b01;
  localparam logic [1:0] SYM_ONE    = 2'b10;
  localparam logic [1:0] SYM_MARKER = 2'b11;

  // Channel and direction encodings, shared with the sender.
  localparam logic CH_1     = 1'b0;
  localparam logic CH_2     = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  function automatic logic is_data(input logic [1:0] sym);
    return (sym == SYM_ZERO) || (sym == SYM_ONE);
  endfunction

endpackage

// File: rtl/dual_rail_receiver_rail_sync.sv
// Synchronizes both rails and reports a symbol once it has been steady for SETTLE_CYCLES samples.
// Latency: 2 synchronizer cycles + SETTLE_CYCLES from rail change to stable_strobe.
// Backpressure: none; stable_strobe is a single-cycle event per settled pattern.
// Ports: clk/reset (sync, active-high); bit0_in/bit1_in async rails;
//        sym = last settled/settling pattern {bit1,bit0}; stable_strobe = pulse when sym becomes stable.
module rail_sync #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit0_in,
  input  logic       bit1_in,
  output logic [1:0] sym,
  output logic       stable_strobe
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [3:0] run_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= 2'b00;
      sync2         <= 2'b00;
      sym           <= 2'b00;
      run_cnt       <= 4'd0;
      stable_strobe <= 1'b0;
    end else begin
      sync1 <= {bit1_in, bit0_in};
      sync2 <= sync1;
      if (sync2 != sym) begin
        // Any change restarts the run; the new sample is the first of the run.
        sym           <= sync2;
        run_cnt       <= 4'd1;
        stable_strobe <= (SETTLE == 4'd1);
      end else if (run_cnt < SETTLE) begin
        run_cnt       <= run_cnt + 4'd1;
        stable_strobe <= ((run_cnt + 4'd1) == SETTLE);
      end else begin
        // Saturated: report each settled pattern only once.
        stable_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dual_rail_receiver.sv
// Decodes marker/channel/direction/marker dual-rail frames with a four-phase RTZ handshake per symbol.
// Latency: rail edge to ack rise = 2 + SETTLE_CYCLES + 1 cycles; frame_valid pulses with the final ack rise.
// Backpressure: sender is paced by ack; a new symbol is only taken after the spacer has been seen.
// Ports: clk, reset (sync, active-high); bit0_in/bit1_in async rails; ack to sender;
//        frame_valid pulse with ch_sel/dir_up (held between frames); err pulse; busy = not IDLE.
// Optional: define RX_TIMEOUT_EN to abort to IDLE after TIMEOUT_CYCLES in any non-IDLE state.
module dual_rail_receiver
  import dual_rail_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic bit0_in,
  input  logic bit1_in,
  output logic ack,
  output logic frame_valid,
  output logic ch_sel,
  output logic dir_up,
  output logic err,
  output logic busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("dual_rail_receiver: parameter out of range");
  end

  rx_state_e  state, state_nxt;
  rx_state_e  ret_state, ret_nxt;
  logic       ch_shadow, ch_shadow_nxt;
  logic       dir_shadow, dir_shadow_nxt;
  logic       ch_sel_nxt, dir_up_nxt;
  logic       frame_valid_nxt, err_nxt;
  logic [1:0] sym;
  logic       stable_strobe;
  logic       timed_out;

  rail_sync #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_rail_sync (
    .clk          (clk),
    .reset        (reset),
    .bit0_in      (bit0_in),
    .bit1_in      (bit1_in),
    .sym          (sym),
    .stable_strobe(stable_strobe)
  );

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;

  // Counts cycles spent in the current state; restarts whenever the state moves.
  always_ff @(posedge clk) begin
    if (reset || (state_nxt != state)) to_cnt <= '0;
    else                               to_cnt <= to_cnt + 1'b1;
  end

  assign timed_out = (state != ST_IDLE) && (to_cnt == TO_LAST);
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    ret_nxt         = ret_state;
    ch_shadow_nxt   = ch_shadow;
    dir_shadow_nxt  = dir_shadow;
    ch_sel_nxt      = ch_sel;
    dir_up_nxt      = dir_up;
    frame_valid_nxt = 1'b0;
    err_nxt         = 1'b0;

    if (timed_out) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
    end else if (stable_strobe) begin
      // Every accepted non-spacer symbol is acknowledged via WAIT_SPACER, even on error,
      // so the sender always completes its handshake.
      unique case (state)
        ST_IDLE: begin
          if (sym == SYM_MARKER) begin
            state_nxt = ST_WAIT_SPACER;
            ret_nxt   = ST_GET_CH;
          end else if (is_data(sym)) begin
            state_nxt = ST_WAIT_SPACER;
            ret_nxt   = ST_IDLE;
            err_nxt   = 1'b1;
          end
        end
        ST_GET_CH: begin
          if (is_data(sym)) begin
            ch_shadow_nxt = (sym == SYM_ONE) ? CH_2 : CH_1;
            state_nxt     = ST_WAIT_SPACER;
            ret_nxt       = ST_GET_DIR;
          end else if (sym == SYM_MARKER) begin
            // A repeated start marker restarts the frame.
            state_nxt = ST_WAIT_SPACER;
            ret_nxt   = ST_GET_CH;
            err_nxt   = 1'b1;
          end
        end
        ST_GET_DIR: begin
          if (is_data(sym)) begin
            dir_shadow_nxt = (sym == SYM_ONE) ? DIR_UP : DIR_DOWN;
            state_nxt      = ST_WAIT_SPACER;
            ret_nxt        = ST_GET_END;
          end else if (sym == SYM_MARKER) begin
            state_nxt = ST_WAIT_SPACER;
            ret_nxt   = ST_GET_CH;
            err_nxt   = 1'b1;
          end
        end
        ST_GET_END: begin
          if (sym == SYM_MARKER) begin
            ch_sel_nxt      = ch_shadow;
            dir_up_nxt      = dir_shadow;
            frame_valid_nxt = 1'b1;
            state_nxt       = ST_WAIT_SPACER;
            ret_nxt         = ST_IDLE;
          end else if (is_data(sym)) begin
            state_nxt = ST_WAIT_SPACER;
            ret_nxt   = ST_IDLE;
            err_nxt   = 1'b1;
          end
        end
        ST_WAIT_SPACER: begin
          if (sym == SYM_SPACER) state_nxt = ret_state;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ret_state   <= ST_IDLE;
      ch_shadow   <= 1'b0;
      dir_shadow  <= 1'b0;
      ch_sel      <= 1'b0;
      dir_up      <= 1'b0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      ret_state   <= ret_nxt;
      ch_shadow   <= ch_shadow_nxt;
      dir_shadow  <= dir_shadow_nxt;
      ch_sel      <= ch_sel_nxt;
      dir_up      <= dir_up_nxt;
      frame_valid <= frame_valid_nxt;
      err         <= err_nxt;
    end
  end

  assign ack  = (state == ST_WAIT_SPACER);
  assign busy = (state != ST_IDLE);

endmodule

// File: doc/dual_rail_receiver.md
Name: dual_rail_receiver

Overview:
- Downstream stage of the dual-rail sender; consumes its bit0/bit1 rails and drives its ack input.
- Decodes one four-symbol frame per command: start marker, channel bit, direction bit, end marker.
- Presents the decoded channel and direction to the local controller with a one-cycle frame_valid pulse.
- Runs four-phase return-to-zero handshake per symbol; rails are asynchronous to clk.

Parameters:
- SETTLE_CYCLES, 2, consecutive identical synchronized rail samples required before a symbol or spacer is accepted (1..15).
- TIMEOUT_CYCLES, 1024, max cycles in any non-IDLE state before abort (only with RX_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- bit0_in  input  1  rail 0 from sender, async
- bit1_in  input  1  rail 1 from sender, async
- ack  output  1  handshake acknowledge to sender
- frame_valid  output  1  one-cycle pulse, decoded frame on ch_sel/dir_up
- ch_sel  output  1  0=Ch1, 1=Ch2; held until next frame_valid
- dir_up  output  1  0=Down, 1=Up; held until next frame_valid
- err  output  1  one-cycle pulse on protocol violation
- busy  output  1  high in any state except IDLE

Behaviour:
- Symbol encoding on synchronized rails {bit1,bit0}: 00 spacer, 01 data '0', 10 data '1', 11 marker.
- Both rails pass a 2-flop synchronizer; a pattern is "stable" after SETTLE_CYCLES equal consecutive samples; stability counter restarts on any change.
- Handshake per symbol: stable non-spacer -> capture, ack=1 -> wait stable spacer -> ack=0 -> next field.
- States: IDLE, GET_CH, GET_DIR, GET_END, WAIT_SPACER (holds ack=1, records next state).
- IDLE: stable marker -> WAIT_SPACER, next=GET_CH. Stable data symbol -> ack it, err pulse, next=IDLE (sender never deadlocks).
- GET_CH: stable data -> ch_shadow=bit1, next=GET_DIR. Stable marker -> err pulse, treated as new start, next=GET_CH.
- GET_DIR: stable data -> dir_shadow=bit1, next=GET_END. Marker -> err, next=GET_CH.
- GET_END: stable marker -> ch_sel/dir_up loaded from shadows, frame_valid=1 in the cycle ack rises, next=IDLE. Data symbol -> err, ack it, next=IDLE, outputs unchanged.
- WAIT_SPACER: ack=1; stable 00 -> ack=0 in next cycle, go to recorded state. Any other pattern change without reaching 00 is ignored.
- Latency from rail edge to ack rise: 2 (sync) + SETTLE_CYCLES + 1 cycles.
- err and frame_valid never assert in the same cycle.
- Reset (any state, mid-frame included): next edge -> IDLE, ack=0, frame_valid=0, err=0, busy=0, ch_sel=0, dir_up=0, shadows/counters cleared, sync flops cleared.
- Glitch shorter than SETTLE_CYCLES on either rail: no state change.

Optional Feature:
- RX_TIMEOUT_EN defined: free-running counter cleared on every state change; reaching TIMEOUT_CYCLES-1 in a non-IDLE state -> err pulse, ack=0, state IDLE, outputs held. Counter width $clog2(TIMEOUT_CYCLES).
- Not defined: no counter; receiver waits indefinitely; TIMEOUT_CYCLES unused.

Decomposition:
- Shared package dual_rail_pkg: state enum, symbol constants SYM_SPACER/SYM_ZERO/SYM_ONE/SYM_MARKER, channel/direction encodings (shared with the sender side).
- One sub-module: rail_sync — 2-flop synchronizer plus stability counter per rail pair, outputs stable 2-bit symbol and stable_strobe.

Test Plan:
- Reset, then frame marker,'1','1',marker with SETTLE_CYCLES=2 -> four ack pulses, frame_valid once, ch_sel=1, dir_up=1; ack rises 5 cycles after each rail edge.
- Frame marker,'0','0',marker after previous frame -> ch_sel=0, dir_up=0; outputs stayed 1/1 until this frame_valid.
- Stray data '1' in IDLE -> ack handshake completes, err pulse, no frame_valid, busy returns 0.
- 1-cycle glitch on bit0 during spacer -> no ack, no state change; glitch on bit1 in GET_END with rails 11 held -> still accepted as marker.
- Reset asserted while ack=1 in GET_DIR -> next cycle ack=0, busy=0, ch_sel/dir_up=0; subsequent full frame decodes correctly.
- With RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: marker then rails frozen at 11 -> err at cycle 16 after entering WAIT_SPACER, ack=0, IDLE; without macro, ack stays 1 indefinitely.
